dcache: RTL and testbench
=========================

DCACHE -- requirements
Module: dcache

Interface
REQ-001 Parameter NUM_LINES, default NUM_CACHE_LINES (4), number of direct-mapped lines; power of two, >=2.
REQ-002 Parameter LINE_WIDTH, default 128, bits per line; power of two multiple of XLEN.
REQ-003 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-low reset (reset=0 resets on the next rising clk edge).
REQ-005 Port req_valid_in  input  1  core/store-buffer access request present.
REQ-006 Port req_write_in  input  1  1=store (store-buffer eviction), 0=load.
REQ-007 Port req_addr_in  input  ADDRESS_WIDTH  byte address.
REQ-008 Port req_wdata_in  input  XLEN  store data; byte stores use bits 7:0.
REQ-009 Port req_size_in  input  data_size_e  B or W.
REQ-010 Port req_ready_out  output  1  access completed this cycle (hit); else requester stalls.
REQ-011 Port rdata_out  output  XLEN  load data, valid when req_ready_out & ~req_write_in.
REQ-012 Port mem_req_out  output  1  memory/arbiter request.
REQ-013 Port mem_write_out  output  1  1=line writeback, 0=line fill.
REQ-014 Port mem_addr_out  output  ADDRESS_WIDTH  line-aligned address (offset bits zero).
REQ-015 Port mem_wdata_out  output  LINE_WIDTH  victim line data.
REQ-016 Port mem_ack_in  input  1  memory accepted write or returned fill data this cycle.
REQ-017 Port mem_rdata_in  input  LINE_WIDTH  fill data, valid with mem_ack_in on a fill.

Function
REQ-018 Address split: offset = log2(LINE_WIDTH/8) LSBs, index = next log2(NUM_LINES) bits, tag = remaining MSBs.
REQ-019 Per line SHALL hold valid, dirty, tag, data; direct-mapped, write-back, write-allocate.
REQ-020 FSM states: IDLE, WRITEBACK, FILL.
REQ-021 Hit = state IDLE & req_valid_in & valid[index] & tag match; req_ready_out = hit, combinational same cycle.
REQ-022 Load hit: W returns word at offset[..:2] (addr[1:0] ignored); B returns addressed byte zero-extended.
REQ-023 Store hit: at that clock edge write word or single byte into line, set dirty[index]; other bytes unchanged.
REQ-024 Miss in IDLE: victim valid & dirty -> WRITEBACK; otherwise -> FILL; req_ready_out=0.
REQ-025 WRITEBACK: mem_req_out=1, mem_write_out=1, mem_addr_out={victim tag,index,0}, mem_wdata_out=victim data, all stable until mem_ack_in; on ack -> FILL.
REQ-026 FILL: mem_req_out=1, mem_write_out=0, mem_addr_out={req tag,index,0}; on mem_ack_in capture mem_rdata_in, valid=1, tag=req tag, dirty=0 -> IDLE.
REQ-027 Each memory state lasts >=1 cycle; mem_ack_in in the first cycle of a state is legal.
REQ-028 Requester SHALL hold req_* stable while req_ready_out=0; the retried access hits in the cycle after FILL completes (miss penalty = 1 + WB cycles + FILL cycles).
REQ-029 mem_ack_in while IDLE SHALL be ignored; mem_req_out=0 in IDLE.
REQ-030 req_valid_in=0 in IDLE: no state change, req_ready_out=0, no memory traffic.
REQ-031 rdata_out SHALL be 0 whenever req_ready_out=0 or req_write_in=1.

Reset
REQ-032 reset=0 at a clk edge: all valid and dirty bits 0, FSM IDLE; outputs req_ready_out=0, mem_req_out=0, mem_write_out=0, mem_addr_out=0, mem_wdata_out=0, rdata_out=0; data/tag arrays need not clear.
REQ-033 Reset during WRITEBACK or FILL SHALL abort: mem_req_out=0 the next cycle, no line updated by a coincident mem_ack_in.

Verification
REQ-034 Cold load W 0x0000_0040: miss -> FILL addr 0x40; ack with line word0=0xDEADBEEF -> next cycle req_ready_out=1, rdata_out=0xDEADBEEF.
REQ-035 Store B 0xAB to 0x41 after REQ-034 fill: ready same cycle; load W 0x40 -> 0xDEADABEF; load B 0x41 -> 0x000000AB.
REQ-036 Load W 0x0000_0080 (same index, NUM_LINES=4, 16-B lines) after REQ-035: WRITEBACK addr 0x40 with word0=0xDEADABEF, then FILL addr 0x80, then hit.
REQ-037 Miss to clean victim: no WRITEBACK, FILL directly; mem_ack_in delayed 5 cycles -> mem_req_out/addr held stable all 5 cycles.
REQ-038 Assert reset=0 in FILL with mem_ack_in=1 same edge: next cycle mem_req_out=0, re-access of that address misses.

Source files
------------

// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache with a single line-wide
// memory port used for both victim writebacks and line fills.
package dcache_pkg;
  localparam int XLEN            = 32;
  localparam int ADDRESS_WIDTH   = 32;
  localparam int NUM_CACHE_LINES = 4;

  typedef enum logic {
    SIZE_B = 1'b0,
    SIZE_W = 1'b1
  } data_size_e;
endpackage

module dcache
  import dcache_pkg::*;
#(
  parameter int NUM_LINES  = NUM_CACHE_LINES,
  parameter int LINE_WIDTH = 128
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid_in,
  input  logic                     req_write_in,
  input  logic [ADDRESS_WIDTH-1:0] req_addr_in,
  input  logic [XLEN-1:0]          req_wdata_in,
  input  data_size_e               req_size_in,
  output logic                     req_ready_out,
  output logic [XLEN-1:0]          rdata_out,
  output logic                     mem_req_out,
  output logic                     mem_write_out,
  output logic [ADDRESS_WIDTH-1:0] mem_addr_out,
  output logic [LINE_WIDTH-1:0]    mem_wdata_out,
  input  logic                     mem_ack_in,
  input  logic [LINE_WIDTH-1:0]    mem_rdata_in
);

  localparam int LINE_BYTES    = LINE_WIDTH / 8;
  localparam int WORD_BYTES    = XLEN / 8;
  localparam int WORDS         = LINE_WIDTH / XLEN;
  localparam int OFFSET_BITS   = $clog2(LINE_BYTES);
  localparam int INDEX_BITS    = $clog2(NUM_LINES);
  localparam int TAG_BITS      = ADDRESS_WIDTH - OFFSET_BITS - INDEX_BITS;
  localparam int BYTE_SEL_BITS = $clog2(WORD_BYTES);
  localparam int WORD_SEL_BITS = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WRITEBACK = 2'd1;
  localparam logic [1:0] ST_FILL      = 2'd2;

  logic [1:0]               state_reg, state_next;
  logic [NUM_LINES-1:0]     valid_reg, dirty_reg;
  logic [TAG_BITS-1:0]      tag_mem  [NUM_LINES];
  logic [LINE_WIDTH-1:0]    data_mem [NUM_LINES];
  logic [INDEX_BITS-1:0]    fill_index_reg, fill_index_next;
  logic [TAG_BITS-1:0]      fill_tag_reg, fill_tag_next;
  logic [ADDRESS_WIDTH-1:0] mem_addr_reg, mem_addr_next;
  logic [LINE_WIDTH-1:0]    mem_wdata_reg, mem_wdata_next;

  logic [OFFSET_BITS-1:0]   req_offset;
  logic [INDEX_BITS-1:0]    req_index;
  logic [TAG_BITS-1:0]      req_tag;
  logic [WORD_SEL_BITS-1:0] word_sel;
  logic [BYTE_SEL_BITS-1:0] byte_sel;
  logic [LINE_WIDTH-1:0]    line_rd;
  logic [LINE_WIDTH-1:0]    store_line;
  logic [XLEN-1:0]          line_word;
  logic [7:0]               line_byte;
  logic                     hit, miss, store_hit, fill_done;

  assign {req_tag, req_index, req_offset} = req_addr_in;
  assign word_sel  = WORD_SEL_BITS'(req_offset >> BYTE_SEL_BITS);
  assign byte_sel  = req_offset[BYTE_SEL_BITS-1:0];
  assign line_rd   = data_mem[req_index];
  assign line_word = line_rd[word_sel*XLEN +: XLEN];
  assign line_byte = line_word[byte_sel*8 +: 8];

  assign hit       = (state_reg == ST_IDLE) && req_valid_in && valid_reg[req_index] &&
                     (tag_mem[req_index] == req_tag);
  assign miss      = (state_reg == ST_IDLE) && req_valid_in && !hit;
  assign store_hit = hit && req_write_in;
  // A fill acknowledged in the same edge as reset must not land in the array.
  assign fill_done = (state_reg == ST_FILL) && mem_ack_in && reset;

  assign req_ready_out = hit;
  assign mem_req_out   = (state_reg != ST_IDLE);
  assign mem_write_out = (state_reg == ST_WRITEBACK);
  assign mem_addr_out  = mem_addr_reg;
  assign mem_wdata_out = mem_wdata_reg;

  always_comb begin
    rdata_out = '0;
    if (hit && !req_write_in) begin
      if (req_size_in == SIZE_W) rdata_out = line_word;
      else                       rdata_out = {{(XLEN-8){1'b0}}, line_byte};
    end
  end

  // Byte-granular merge of store data into the currently indexed line.
  genvar gi;
  generate
    for (gi = 0; gi < LINE_BYTES; gi++) begin : g_store_byte
      logic byte_we;
      assign byte_we = (req_size_in == SIZE_W) ?
                       (WORD_SEL_BITS'(gi / WORD_BYTES) == word_sel) :
                       (OFFSET_BITS'(gi) == req_offset);
      assign store_line[gi*8 +: 8] = !byte_we ? line_rd[gi*8 +: 8] :
                                     (req_size_in == SIZE_W) ?
                                     req_wdata_in[(gi % WORD_BYTES)*8 +: 8] :
                                     req_wdata_in[7:0];
    end
  endgenerate

  always_comb begin
    state_next      = state_reg;
    fill_index_next = fill_index_reg;
    fill_tag_next   = fill_tag_reg;
    mem_addr_next   = mem_addr_reg;
    mem_wdata_next  = mem_wdata_reg;
    case (state_reg)
      ST_IDLE: begin
        if (miss) begin
          fill_index_next = req_index;
          fill_tag_next   = req_tag;
          if (valid_reg[req_index] && dirty_reg[req_index]) begin
            state_next     = ST_WRITEBACK;
            mem_addr_next  = {tag_mem[req_index], req_index, {OFFSET_BITS{1'b0}}};
            mem_wdata_next = line_rd;
          end else begin
            state_next     = ST_FILL;
            mem_addr_next  = {req_tag, req_index, {OFFSET_BITS{1'b0}}};
            mem_wdata_next = '0;
          end
        end
      end
      ST_WRITEBACK: begin
        if (mem_ack_in) begin
          state_next     = ST_FILL;
          mem_addr_next  = {fill_tag_reg, fill_index_reg, {OFFSET_BITS{1'b0}}};
          mem_wdata_next = '0;
        end
      end
      ST_FILL: begin
        if (mem_ack_in) begin
          state_next    = ST_IDLE;
          mem_addr_next = '0;
        end
      end
      default: begin
        state_next     = ST_IDLE;
        mem_addr_next  = '0;
        mem_wdata_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      valid_reg      <= '0;
      dirty_reg      <= '0;
      fill_index_reg <= '0;
      fill_tag_reg   <= '0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      fill_index_reg <= fill_index_next;
      fill_tag_reg   <= fill_tag_next;
      mem_addr_reg   <= mem_addr_next;
      mem_wdata_reg  <= mem_wdata_next;
      if (store_hit) dirty_reg[req_index] <= 1'b1;
      if (fill_done) begin
        valid_reg[fill_index_reg] <= 1'b1;
        dirty_reg[fill_index_reg] <= 1'b0;
      end
    end
  end

  // Tag and data arrays carry no reset; the valid bits gate their use.
  always_ff @(posedge clk) begin
    if (store_hit) begin
      data_mem[req_index] <= store_line;
    end else if (fill_done) begin
      data_mem[fill_index_reg] <= mem_rdata_in;
      tag_mem[fill_index_reg]  <= fill_tag_reg;
    end
  end

endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: directed vector table, reset corner cases and
// randomized accesses checked against a flat-memory reference model.
module tb_dcache;
  import dcache_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid, req_write;
  logic [31:0]  req_addr, req_wdata;
  data_size_e   req_size;
  logic         req_ready;
  logic [31:0]  rdata;
  logic         mem_req, mem_write;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         mem_ack;
  logic [127:0] mem_rdata;

  always #5 clk = ~clk;

  dcache dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid_in  (req_valid),
    .req_write_in  (req_write),
    .req_addr_in   (req_addr),
    .req_wdata_in  (req_wdata),
    .req_size_in   (req_size),
    .req_ready_out (req_ready),
    .rdata_out     (rdata),
    .mem_req_out   (mem_req),
    .mem_write_out (mem_write),
    .mem_addr_out  (mem_addr),
    .mem_wdata_out (mem_wdata),
    .mem_ack_in    (mem_ack),
    .mem_rdata_in  (mem_rdata)
  );

  int n_pass = 0;
  int n_total = 0;

  // Backing memory (line granular) and the architectural view of memory (word granular).
  logic [127:0] mem_lines [logic [31:0]];
  logic [31:0]  gold      [logic [31:0]];
  logic [31:0]  m_line [4];
  bit           m_valid [4];
  bit           m_dirty [4];

  // Per-access observations filled by do_access.
  int          n_wb, n_fill, n_cyc;
  bit          timeout, stable_ok, wb_data_ok;
  logic [31:0] rd_val, last_wb_addr, last_fill_addr, last_wb_word0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    data_size_e  sz;
    logic [31:0] wd;
    int          dly;
    bit          exp_hit;
    bit          exp_wb;
    logic [31:0] exp_wb_addr;
    logic [31:0] exp_wb_w0;
    logic [31:0] exp_fill_addr;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [127:0] backing_line(input logic [31:0] la);
    logic [127:0] l;
    if (mem_lines.exists(la)) return mem_lines[la];
    for (int k = 0; k < 4; k++) l[k*32 +: 32] = init_word(la + 32'(4*k));
    return l;
  endfunction

  function automatic logic [31:0] gold_word(input logic [31:0] wa);
    logic [127:0] l;
    if (gold.exists(wa)) return gold[wa];
    l = backing_line({wa[31:4], 4'h0});
    return l[wa[3:2]*32 +: 32];
  endfunction

  function automatic logic [127:0] gold_line(input logic [31:0] la);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[k*32 +: 32] = gold_word(la + 32'(4*k));
    return l;
  endfunction

  function automatic logic [31:0] expect_load(input logic [31:0] a, input data_size_e sz);
    logic [31:0] w;
    w = gold_word({a[31:2], 2'b00});
    if (sz == SIZE_W) return w;
    return {24'h0, w[a[1:0]*8 +: 8]};
  endfunction

  function automatic void model_update(input logic wr, input logic [31:0] a,
                                       input data_size_e sz, input logic [31:0] wd);
    int          idx;
    logic [31:0] w;
    idx = int'((a >> 4) % 4);
    if (!(m_valid[idx] && m_line[idx] == {a[31:4], 4'h0})) begin
      m_valid[idx] = 1'b1;
      m_line[idx]  = {a[31:4], 4'h0};
      m_dirty[idx] = 1'b0;
    end
    if (wr) begin
      m_dirty[idx] = 1'b1;
      w = gold_word({a[31:2], 2'b00});
      if (sz == SIZE_W) w = wd;
      else              w[a[1:0]*8 +: 8] = wd[7:0];
      gold[{a[31:2], 2'b00}] = w;
    end
  endfunction

  function automatic void model_reset();
    gold.delete();
    for (int k = 0; k < 4; k++) begin
      m_valid[k] = 1'b0;
      m_dirty[k] = 1'b0;
    end
  endfunction

  // Issue one access (entered just after a falling edge) and act as memory until it completes.
  task automatic do_access(input logic wr, input logic [31:0] a, input data_size_e sz,
                           input logic [31:0] wd, input int dly);
    int           wait_cnt;
    logic [31:0]  hold_addr;
    logic         hold_w;
    logic [127:0] hold_data;
    n_wb = 0; n_fill = 0; n_cyc = 0; wait_cnt = 0;
    timeout = 0; stable_ok = 1; wb_data_ok = 1; rd_val = '0;
    hold_addr = '0; hold_w = 1'b0; hold_data = '0;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_size = sz; req_wdata = wd;
    mem_ack = 1'b0;
    forever begin
      #1;
      if (req_ready) begin
        rd_val = rdata;
        break;
      end
      if (mem_req) begin
        if (wait_cnt == 0) begin
          hold_addr = mem_addr; hold_w = mem_write; hold_data = mem_wdata;
        end else if (mem_addr !== hold_addr || mem_write !== hold_w || mem_wdata !== hold_data) begin
          stable_ok = 0;
        end
        if (wait_cnt == dly) begin
          mem_ack = 1'b1;
          if (mem_write) begin
            n_wb++;
            last_wb_addr  = mem_addr;
            last_wb_word0 = mem_wdata[31:0];
            if (mem_wdata !== gold_line(mem_addr)) wb_data_ok = 0;
            mem_lines[mem_addr] = mem_wdata;
          end else begin
            n_fill++;
            last_fill_addr = mem_addr;
            mem_rdata = backing_line(mem_addr);
          end
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
      @(negedge clk);
      mem_ack = 1'b0;
      n_cyc++;
      if (n_cyc > 200) begin
        timeout = 1;
        break;
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    mem_ack = 1'b0;
  endtask

  task automatic check_access(input string nm, input logic wr, input int dly, input bit exp_hit,
                              input bit exp_wb, input logic [31:0] exp_wb_addr,
                              input logic [31:0] exp_fill_addr, input logic [31:0] exp_rdata);
    int exp_cyc;
    exp_cyc = exp_hit ? 0 : 1 + (exp_wb ? dly + 1 : 0) + dly + 1;
    check({nm, " timeout"}, 32'(timeout), 32'd0);
    check({nm, " cycles"}, 32'(n_cyc), 32'(exp_cyc));
    check({nm, " wb_count"}, 32'(n_wb), exp_wb ? 32'd1 : 32'd0);
    if (exp_wb && n_wb > 0) begin
      check({nm, " wb_addr"}, last_wb_addr, exp_wb_addr);
      check({nm, " wb_data_ok"}, 32'(wb_data_ok), 32'd1);
    end
    if (!exp_hit) begin
      check({nm, " fill_count"}, 32'(n_fill), 32'd1);
      check({nm, " fill_addr"}, last_fill_addr, exp_fill_addr);
      check({nm, " mem_stable"}, 32'(stable_ok), 32'd1);
    end
    check({nm, " rdata"}, rd_val, wr ? 32'd0 : exp_rdata);
  endtask

  initial begin
    logic [127:0] l40;
    int           guard;

    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = SIZE_W; mem_ack = 1'b0; mem_rdata = '0;
    model_reset();
    l40 = backing_line(32'h40);
    l40[31:0] = 32'hDEAD_BEEF;
    mem_lines[32'h40] = l40;

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset req_ready", 32'(req_ready), 32'd0);
    check("reset mem_req", 32'(mem_req), 32'd0);
    check("reset mem_write", 32'(mem_write), 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    check("reset mem_wdata_nz", 32'(|mem_wdata), 32'd0);
    check("reset rdata", rdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Idle with no request: no traffic, nothing ready.
    repeat (3) begin
      @(negedge clk); #1;
      check("idle mem_req", 32'(mem_req), 32'd0);
      check("idle req_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk);

    //           wr    addr        size    wdata          dly hit wb  wb_addr  wb_w0          fill      rdata
    vecs[0] = '{1'b0, 32'h40, SIZE_W, 32'h0,          0, 0, 0, 32'h0,  32'h0,         32'h40, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 32'h41, SIZE_B, 32'h1234_56AB,  0, 1, 0, 32'h0,  32'h0,         32'h0,  32'h0};
    vecs[2] = '{1'b0, 32'h40, SIZE_W, 32'h0,          0, 1, 0, 32'h0,  32'h0,         32'h0,  32'hDEAD_ABEF};
    vecs[3] = '{1'b0, 32'h41, SIZE_B, 32'h0,          0, 1, 0, 32'h0,  32'h0,         32'h0,  32'h0000_00AB};
    vecs[4] = '{1'b0, 32'h43, SIZE_B, 32'h0,          0, 1, 0, 32'h0,  32'h0,         32'h0,  32'h0000_00DE};
    vecs[5] = '{1'b0, 32'h80, SIZE_W, 32'h0,          0, 0, 1, 32'h40, 32'hDEAD_ABEF, 32'h80, init_word(32'h80)};
    vecs[6] = '{1'b0, 32'hC4, SIZE_W, 32'h0,          5, 0, 0, 32'h0,  32'h0,         32'hC0, init_word(32'hC4)};

    for (int i = 0; i < 7; i++) begin
      do_access(vecs[i].wr, vecs[i].addr, vecs[i].sz, vecs[i].wd, vecs[i].dly);
      check_access($sformatf("vec%0d", i), vecs[i].wr, vecs[i].dly, vecs[i].exp_hit,
                   vecs[i].exp_wb, vecs[i].exp_wb_addr, vecs[i].exp_fill_addr, vecs[i].exp_rdata);
      if (vecs[i].exp_wb) check($sformatf("vec%0d wb_word0", i), last_wb_word0, vecs[i].exp_wb_w0);
      model_update(vecs[i].wr, vecs[i].addr, vecs[i].sz, vecs[i].wd);
      $display("vec%0d wr=%0d addr=0x%08h cycles=%0d wb=%0d rdata=0x%08h",
               i, vecs[i].wr, vecs[i].addr, n_cyc, n_wb, rd_val);
    end

    // Reset arriving together with a fill acknowledge aborts the fill.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h100; req_size = SIZE_W;
    guard = 0;
    #1;
    while (!(mem_req && !mem_write) && guard < 10) begin
      @(negedge clk); #1;
      guard++;
    end
    check("abort reached fill", 32'(mem_req && !mem_write), 32'd1);
    mem_ack = 1'b1; mem_rdata = {4{32'hBAD0_BAD0}}; reset = 1'b0;
    @(negedge clk);
    reset = 1'b1; mem_ack = 1'b0; req_valid = 1'b0;
    #1;
    check("abort mem_req", 32'(mem_req), 32'd0);
    check("abort mem_addr", mem_addr, 32'd0);
    check("abort req_ready", 32'(req_ready), 32'd0);
    model_reset();
    @(negedge clk);
    do_access(1'b0, 32'h100, SIZE_W, 32'h0, 0);
    check_access("abort reaccess", 1'b0, 0, 1'b0, 1'b0, 32'h0, 32'h100, init_word(32'h100));
    model_update(1'b0, 32'h100, SIZE_W, 32'h0);
    $display("abort reaccess cycles=%0d rdata=0x%08h", n_cyc, rd_val);

    // Randomized traffic against the reference model, with stray acks while idle.
    for (int i = 0; i < 250; i++) begin
      logic [31:0] a, wd, exp_rd;
      logic        wr;
      data_size_e  sz;
      int          dly, idx;
      bit          p_hit, p_wb;
      a   = 32'($urandom_range(0, 32'h1FF));
      wr  = ($urandom_range(0, 9) < 4);
      sz  = ($urandom_range(0, 1) == 1) ? SIZE_W : SIZE_B;
      wd  = $urandom;
      dly = $urandom_range(0, 3);
      idx = int'((a >> 4) % 4);
      p_hit  = m_valid[idx] && (m_line[idx] == {a[31:4], 4'h0});
      p_wb   = !p_hit && m_valid[idx] && m_dirty[idx];
      exp_rd = expect_load(a, sz);
      do_access(wr, a, sz, wd, dly);
      check_access($sformatf("rnd%0d", i), wr, dly, p_hit, p_wb, m_line[idx],
                   {a[31:4], 4'h0}, exp_rd);
      model_update(wr, a, sz, wd);
      $display("rnd%0d wr=%0d sz=%0d addr=0x%08h cycles=%0d wb=%0d rdata=0x%08h",
               i, wr, sz, a, n_cyc, n_wb, rd_val);
      repeat ($urandom_range(0, 2)) begin
        mem_ack = 1'($urandom_range(0, 1));
        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        #1;
        check("gap mem_req", 32'(mem_req), 32'd0);
        check("gap rdata", rdata, 32'd0);
        @(negedge clk);
        mem_ack = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
